// File: rtl/counter_mon_pkg.sv
// ----------------------------------------------------------------------------
// counter_mon_pkg
// Shared types and constants for the up/down load counter monitor.
//   mon_state_e : monitor FSM states (IDLE = tracking, CHECK = comparing,
//                 HALT = stopped after an error until clr)
//   KIND_*      : bit positions inside the 3-bit mismatch-kind vector
//                 {zero_bad, max_bad, count_bad}
// ----------------------------------------------------------------------------
package counter_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        HALT  = 2'd2
    } mon_state_e;

    localparam int KIND_COUNT = 0;
    localparam int KIND_MAX   = 1;
    localparam int KIND_ZERO  = 2;
    localparam int KIND_W     = 3;

endpackage : counter_mon_pkg

// File: rtl/counter_ref_model.sv
// ----------------------------------------------------------------------------
// counter_ref_model
// Combinational golden model of the up/down load counter.
//   base      in  WIDTH  value the next() step is applied to
//   load_n    in  1      active-low load (has priority over ce)
//   up_down   in  1      1 = increment, 0 = decrement
//   ce        in  1      count enable
//   data_load in  WIDTH  load value
//   exp_cur   in  WIDTH  currently expected counter value
//   next_val  out WIDTH  next(base), wrapping modulo 2^WIDTH
//   exp_max   out 1      exp_cur is all ones
//   exp_zero  out 1      exp_cur is zero
// ----------------------------------------------------------------------------
module counter_ref_model #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] base,
    input  logic             load_n,
    input  logic             up_down,
    input  logic             ce,
    input  logic [WIDTH-1:0] data_load,
    input  logic [WIDTH-1:0] exp_cur,
    output logic [WIDTH-1:0] next_val,
    output logic             exp_max,
    output logic             exp_zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_comb begin
        // NOTE: assigning a default before any branch keeps this block purely
        // combinational; a path that leaves next_val unassigned would infer a latch.
        next_val = base;
        if (!load_n) begin
            next_val = data_load;
        end else if (ce) begin
            // Natural modular wrap of the WIDTH-bit adder gives 15+1=0 / 0-1=15.
            next_val = up_down ? (base + ONE) : (base - ONE);
        end
    end

    assign exp_max  = &exp_cur;
    assign exp_zero = ~|exp_cur;

endmodule : counter_ref_model

// File: rtl/counter_monitor.sv
// ----------------------------------------------------------------------------
// counter_monitor
// Passive checker for the up/down load counter. Tracks the counter with its
// own golden model and compares count_out / max_count / zero every cycle while
// checking is enabled. Mismatches are reported one cycle after the offending
// edge as a pulse, a sticky flag, a saturating count and a first-failure capture.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   load_n, up_down, ce,
//   data_load                  observed counter controls
//   count_out, max_count, zero observed counter outputs
//   mon_en                     1 = perform compares (IDLE <-> CHECK)
//   clr                        clear error state; HALT -> IDLE
//   err_pulse                  1-cycle pulse after a mismatching edge
//   err_sticky                 set on any mismatch until clr/reset
//   err_count  [ERR_W]         saturating mismatch count
//   chk_count  [CHK_W]         saturating compare count
//   first_kind [3]             {zero_bad, max_bad, count_bad} of first mismatch
//   first_exp  [WIDTH]         expected count at first mismatch
//   first_got  [WIDTH]         observed count at first mismatch
//   state_o    [2]             current monitor state
// ----------------------------------------------------------------------------
module counter_monitor
    import counter_mon_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int ERR_W       = 8,
    parameter int CHK_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_n,
    input  logic              up_down,
    input  logic              ce,
    input  logic [WIDTH-1:0]  data_load,
    input  logic [WIDTH-1:0]  count_out,
    input  logic              max_count,
    input  logic              zero,
    input  logic              mon_en,
    input  logic              clr,
    output logic              err_pulse,
    output logic              err_sticky,
    output logic [ERR_W-1:0]  err_count,
    output logic [CHK_W-1:0]  chk_count,
    output logic [2:0]        first_kind,
    output logic [WIDTH-1:0]  first_exp,
    output logic [WIDTH-1:0]  first_got,
    output logic [1:0]        state_o
);

    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);
    localparam logic [CHK_W-1:0] CHK_ONE = CHK_W'(1);

    mon_state_e        state_q;
    mon_state_e        state_d;
    logic [WIDTH-1:0]  exp_q;
    logic [WIDTH-1:0]  exp_d;
    logic [WIDTH-1:0]  model_base;
    logic              exp_max;
    logic              exp_zero;
    logic [KIND_W-1:0] kind;
    logic              do_cmp;
    logic              mismatch;

    // ------------------------------------------------------------------
    // Golden model: while checking, the model free-runs from its own
    // expectation; otherwise it re-syncs to whatever the counter shows.
    // ------------------------------------------------------------------
    assign model_base = (state_q == CHECK) ? exp_q : count_out;

    counter_ref_model #(
        .WIDTH (WIDTH)
    ) u_ref_model (
        .base      (model_base),
        .load_n    (load_n),
        .up_down   (up_down),
        .ce        (ce),
        .data_load (data_load),
        .exp_cur   (exp_q),
        .next_val  (exp_d),
        .exp_max   (exp_max),
        .exp_zero  (exp_zero)
    );

    // ------------------------------------------------------------------
    // Compare logic. A mismatch coinciding with clr is dropped so that
    // a clear always leaves the error state fully empty.
    // ------------------------------------------------------------------
    always_comb begin
        kind             = '0;
        kind[KIND_COUNT] = (count_out != exp_q);
        kind[KIND_MAX]   = (max_count != exp_max);
        kind[KIND_ZERO]  = (zero != exp_zero);
        do_cmp           = (state_q == CHECK) && mon_en;
        mismatch         = do_cmp && (|kind) && !clr;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (mon_en) state_d = CHECK;
            end
            CHECK: begin
                if (mismatch && STOP_ON_ERR) state_d = HALT;
                else if (!mon_en)            state_d = IDLE;
            end
            HALT: begin
                if (clr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, expectation and registered compare result
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state_q   <= IDLE;
            exp_q     <= '0;
            err_pulse <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            err_pulse <= mismatch;
        end
    end

    // ------------------------------------------------------------------
    // Statistics and first-failure capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
            chk_count  <= '0;
            first_kind <= '0;
            first_exp  <= '0;
            first_got  <= '0;
        end else if (clr) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
            chk_count  <= '0;
            first_kind <= '0;
            first_exp  <= '0;
            first_got  <= '0;
        end else begin
            if (do_cmp && !(&chk_count)) begin
                chk_count <= chk_count + CHK_ONE;
            end
            if (mismatch) begin
                err_sticky <= 1'b1;
                if (!(&err_count)) begin
                    err_count <= err_count + ERR_ONE;
                end
                // Only the first failure since the last clear is kept.
                if (!err_sticky) begin
                    first_kind <= kind;
                    first_exp  <= exp_q;
                    first_got  <= count_out;
                end
            end
        end
    end

    assign state_o = state_q;

endmodule : counter_monitor

// File: tb/tb_counter_monitor.sv
// ----------------------------------------------------------------------------
// tb_counter_monitor
// Drives a behavioural counter (with fault injection on its outputs) into
// three monitor instances: default parameters, STOP_ON_ERR=1, and narrow
// ERR_W=2 / CHK_W=4 counters. A spec-level model predicts each monitor's
// outputs per clock edge; predictions are queued and a separate monitor
// process pops and compares them after every edge.
// ----------------------------------------------------------------------------
module tb_counter_monitor;

    typedef struct packed {
        logic        pulse;
        logic        sticky;
        logic [15:0] errs;
        logic [15:0] chks;
        logic [2:0]  kind;
        logic [3:0]  fexp;
        logic [3:0]  fgot;
        logic [1:0]  st;
    } obs_t;

    // Spec-level monitor state: mode 0 = tracking, 1 = checking, 2 = halted.
    typedef struct {
        int mode;
        int expv;
        bit pulse;
        bit sticky;
        int errs;
        int chks;
        int kind;
        int fexp;
        int fgot;
    } model_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_n = 1'b1;
    logic       up_down = 1'b1;
    logic       ce = 1'b0;
    logic [3:0] data_load = 4'd0;
    logic [3:0] count_out = 4'd0;
    logic       max_count = 1'b0;
    logic       zero = 1'b1;
    logic       mon_en = 1'b0;
    logic       clr = 1'b0;

    // Fault injection on the observed counter outputs.
    logic [3:0] cnt_x = 4'd0;
    logic       max_x = 1'b0;
    logic       zero_x = 1'b0;
    int         ctr = 0;

    logic       a_pulse, a_sticky, b_pulse, b_sticky, c_pulse, c_sticky;
    logic [7:0] a_err, b_err;
    logic [1:0] c_err;
    logic [15:0] a_chk, b_chk;
    logic [3:0] c_chk;
    logic [2:0] a_kind, b_kind, c_kind;
    logic [3:0] a_fexp, a_fgot, b_fexp, b_fgot, c_fexp, c_fgot;
    logic [1:0] a_st, b_st, c_st;

    int checks = 0;
    int errors = 0;

    model_t m_a = '{default: 0};
    model_t m_b = '{default: 0};
    model_t m_c = '{default: 0};
    obs_t   q_a[$];
    obs_t   q_b[$];
    obs_t   q_c[$];

    always #5 clk = ~clk;

    counter_monitor u_dut_a (
        .clk(clk), .rst_n(rst_n), .load_n(load_n), .up_down(up_down), .ce(ce),
        .data_load(data_load), .count_out(count_out), .max_count(max_count), .zero(zero),
        .mon_en(mon_en), .clr(clr), .err_pulse(a_pulse), .err_sticky(a_sticky),
        .err_count(a_err), .chk_count(a_chk), .first_kind(a_kind), .first_exp(a_fexp),
        .first_got(a_fgot), .state_o(a_st)
    );

    counter_monitor #(.STOP_ON_ERR(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .load_n(load_n), .up_down(up_down), .ce(ce),
        .data_load(data_load), .count_out(count_out), .max_count(max_count), .zero(zero),
        .mon_en(mon_en), .clr(clr), .err_pulse(b_pulse), .err_sticky(b_sticky),
        .err_count(b_err), .chk_count(b_chk), .first_kind(b_kind), .first_exp(b_fexp),
        .first_got(b_fgot), .state_o(b_st)
    );

    counter_monitor #(.ERR_W(2), .CHK_W(4)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .load_n(load_n), .up_down(up_down), .ce(ce),
        .data_load(data_load), .count_out(count_out), .max_count(max_count), .zero(zero),
        .mon_en(mon_en), .clr(clr), .err_pulse(c_pulse), .err_sticky(c_sticky),
        .err_count(c_err), .chk_count(c_chk), .first_kind(c_kind), .first_exp(c_fexp),
        .first_got(c_fgot), .state_o(c_st)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic obs_t mk(input logic p, input logic s, input int e, input int c,
                                input int k, input int fe, input int fg, input int st);
        obs_t o;
        o.pulse  = p;
        o.sticky = s;
        o.errs   = e[15:0];
        o.chks   = c[15:0];
        o.kind   = k[2:0];
        o.fexp   = fe[3:0];
        o.fgot   = fg[3:0];
        o.st     = st[1:0];
        return o;
    endfunction

    function automatic obs_t obs_a();
        return mk(a_pulse, a_sticky, int'(a_err), int'(a_chk), int'(a_kind),
                  int'(a_fexp), int'(a_fgot), int'(a_st));
    endfunction
    function automatic obs_t obs_b();
        return mk(b_pulse, b_sticky, int'(b_err), int'(b_chk), int'(b_kind),
                  int'(b_fexp), int'(b_fgot), int'(b_st));
    endfunction
    function automatic obs_t obs_c();
        return mk(c_pulse, c_sticky, int'(c_err), int'(c_chk), int'(c_kind),
                  int'(c_fexp), int'(c_fgot), int'(c_st));
    endfunction

    function automatic obs_t model_obs(input model_t m);
        return mk(m.pulse, m.sticky, m.errs, m.chks, m.kind, m.fexp, m.fgot, m.mode);
    endfunction

    // Counter next-value rule, in plain modular arithmetic.
    function automatic int nxt(input int b);
        if (!load_n) return int'(data_load);
        if (ce) return up_down ? (b + 1) % 16 : (b + 15) % 16;
        return b;
    endfunction

    // What one clock edge does to a monitor, given the current inputs.
    function automatic model_t model_edge(input model_t m, input bit stop,
                                          input int err_max, input int chk_max);
        model_t n;
        int     k;
        bit     cmp;
        bit     bad;
        n = m;
        if (!rst_n) begin
            n = '{default: 0};
            return n;
        end
        k = 0;
        if (int'(count_out) != m.expv)    k = k | 1;
        if (max_count != (m.expv == 15))  k = k | 2;
        if (zero != (m.expv == 0))        k = k | 4;
        cmp = (m.mode == 1) && mon_en;
        bad = cmp && (k != 0) && !clr;
        n.expv  = (m.mode == 1) ? nxt(m.expv) : nxt(int'(count_out));
        n.pulse = bad;
        case (m.mode)
            0:       n.mode = mon_en ? 1 : 0;
            1:       n.mode = (bad && stop) ? 2 : (mon_en ? 1 : 0);
            default: n.mode = clr ? 0 : 2;
        endcase
        if (clr) begin
            n.sticky = 0;
            n.errs = 0;
            n.chks = 0;
            n.kind = 0;
            n.fexp = 0;
            n.fgot = 0;
        end else begin
            if (cmp && m.chks < chk_max) n.chks = m.chks + 1;
            if (bad) begin
                if (!m.sticky) begin
                    n.kind = k;
                    n.fexp = m.expv;
                    n.fgot = int'(count_out);
                end
                n.sticky = 1;
                if (m.errs < err_max) n.errs = m.errs + 1;
            end
        end
        return n;
    endfunction

    // Present the counter outputs, predict the coming edge, let it happen.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            count_out = 4'(ctr) ^ cnt_x;
            max_count = (ctr == 15) ^ max_x;
            zero      = (ctr == 0) ^ zero_x;
            m_a = model_edge(m_a, 1'b0, 255, 65535);
            m_b = model_edge(m_b, 1'b1, 255, 65535);
            m_c = model_edge(m_c, 1'b0, 3, 15);
            q_a.push_back(model_obs(m_a));
            q_b.push_back(model_obs(m_b));
            q_c.push_back(model_obs(m_c));
            ctr = !rst_n ? 0 : nxt(ctr);
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor: compares every edge's outputs with the prediction.
    initial begin : sb_monitor
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) check("sb_a", obs_a(), q_a.pop_front());
            if (q_b.size() > 0) check("sb_b", obs_b(), q_b.pop_front());
            if (q_c.size() > 0) check("sb_c", obs_c(), q_c.pop_front());
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        // 1: reset, then 20 compares against a correct up-counter (wraps 15->0)
        rst_n = 1'b0;
        tick(2);
        check("reset_a", obs_a(), '0);
        check("reset_b", obs_b(), '0);
        rst_n = 1'b1; mon_en = 1'b1; ce = 1'b1; up_down = 1'b1;
        tick(21);
        check("s1_chk_count", 64'(a_chk), 64'd20);
        check("s1_err_count", 64'(a_err), 64'd0);
        check("s1_chk_sat_w4", 64'(c_chk), 64'd15);

        // 2: load wins over ce; then count down from 0 to 15
        load_n = 1'b0; data_load = 4'd9; ce = 1'b1;
        tick();
        load_n = 1'b1; ce = 1'b0;
        tick();
        check("s2_load_no_err", 64'(a_pulse), 64'd0);
        load_n = 1'b0; data_load = 4'd0;
        tick();
        load_n = 1'b1; ce = 1'b1; up_down = 1'b0;
        tick();
        ce = 1'b0;
        tick();
        check("s2_wrap_down_err", 64'(a_err), 64'd0);
        check("s2_state_check", 64'(a_st), 64'd1);

        // 3: count_out shows 5 where 6 is expected
        clr = 1'b1;
        tick();
        clr = 1'b0; load_n = 1'b0; data_load = 4'd4;
        tick();
        load_n = 1'b1; ce = 1'b1; up_down = 1'b1;
        tick(2);
        ce = 1'b0; cnt_x = 4'd3;
        tick();
        cnt_x = 4'd0;
        check("s3_pulse", 64'(a_pulse), 64'd1);
        check("s3_err_count", 64'(a_err), 64'd1);
        check("s3_first_exp", 64'(a_fexp), 64'd6);
        check("s3_first_got", 64'(a_fgot), 64'd5);
        check("s3_first_kind", 64'(a_kind), 64'b001);
        check("s3_b_halt", 64'(b_st), 64'd2);
        tick();
        check("s3_pulse_1cyc", 64'(a_pulse), 64'd0);

        // 4: zero flag wrong at count 0, then a second (count) error
        clr = 1'b1;
        tick();
        check("s4_b_clr_idle", 64'(b_st), 64'd0);
        clr = 1'b0; load_n = 1'b0; data_load = 4'd0;
        tick();
        load_n = 1'b1; zero_x = 1'b1;
        tick();
        zero_x = 1'b0;
        check("s4_first_kind", 64'(a_kind), 64'b100);
        cnt_x = 4'd1;
        tick();
        cnt_x = 4'd0;
        check("s4_err_count2", 64'(a_err), 64'd2);
        check("s4_first_kept", 64'(a_kind), 64'b100);
        check("s4_b_halt_nocount", 64'(b_err), 64'd1);
        check("s4_b_halt_state", 64'(b_st), 64'd2);

        // 5: clr from HALT, clr beats a same-edge mismatch, ERR_W=2 saturation
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("s5_b_cleared", obs_b(), mk(1'b0, 1'b0, 0, 0, 0, 0, 0, 0));
        tick();
        clr = 1'b1; cnt_x = 4'd1;
        tick();
        clr = 1'b0;
        check("s5_clr_wins_pulse", 64'(a_pulse), 64'd0);
        check("s5_clr_wins_count", 64'(a_err), 64'd0);
        tick(5);
        cnt_x = 4'd0;
        check("s5_err_sat_w2", 64'(c_err), 64'd3);
        check("s5_err_a5", 64'(a_err), 64'd5);
        check("s5_b_stop_first", 64'(b_err), 64'd1);

        // 6: enable checking mid-run at count 11; then reset mid-check
        clr = 1'b1; mon_en = 1'b0;
        tick();
        clr = 1'b0; load_n = 1'b0; data_load = 4'd8;
        tick();
        load_n = 1'b1; ce = 1'b1; up_down = 1'b1;
        tick(3);
        mon_en = 1'b1;
        tick(5);
        check("s6_no_false_err", 64'(a_err), 64'd0);
        cnt_x = 4'd2;
        tick();
        cnt_x = 4'd0; rst_n = 1'b0;
        tick();
        check("s6_reset_a", obs_a(), '0);
        check("s6_reset_c", obs_c(), '0);
        rst_n = 1'b1; ce = 1'b0;
        tick(2);
        check("s6_after_rst_chk", 64'(a_chk), 64'd1);
        check("s6_after_rst_err", 64'(a_err), 64'd0);

        // Randomised run with sporadic faults, clears and resets
        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom_range(0, 63) != 0);
            load_n    = ($urandom_range(0, 4) != 0);
            ce        = ($urandom_range(0, 3) != 0);
            up_down   = 1'($urandom_range(0, 1));
            data_load = 4'($urandom_range(0, 15));
            mon_en    = ($urandom_range(0, 7) != 0);
            clr       = ($urandom_range(0, 31) == 0);
            cnt_x     = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            max_x     = ($urandom_range(0, 39) == 0);
            zero_x    = ($urandom_range(0, 39) == 0);
            tick();
        end
        cnt_x = 4'd0; max_x = 1'b0; zero_x = 1'b0; clr = 1'b0; rst_n = 1'b1;
        tick(2);

        @(posedge clk);
        #2;
        check("sb_drain_a", 64'(q_a.size()), 64'd0);
        check("sb_drain_b", 64'(q_b.size()), 64'd0);
        check("sb_drain_c", 64'(q_c.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_counter_monitor
